// File: rtl/csa_block_serial_adder.sv
// Wide adder that reuses one 8-bit carry-skip adder. Each cycle it adds one byte
// slice, least-significant slice first, and registers the carry for the next slice.

module jcarryskipadder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] y,
  output logic       cout
);

  logic [7:0]      p;
  logic [7:0]      g;
  logic [2:0]      c_blk;
  logic [1:0][4:0] rc;

  assign p = a ^ b;
  assign g = a & b;

  // Two 4-bit ripple blocks; a block whose bits all propagate passes its carry-in straight through.
  always_comb begin
    c_blk    = '0;
    rc       = '0;
    y        = '0;
    c_blk[0] = cin;
    for (int k = 0; k < 2; k++) begin
      rc[k][0] = c_blk[k];
      for (int i = 0; i < 4; i++) begin
        y[4*k+i]   = p[4*k+i] ^ rc[k][i];
        rc[k][i+1] = g[4*k+i] | (p[4*k+i] & rc[k][i]);
      end
      c_blk[k+1] = (&p[4*k +: 4]) ? c_blk[k] : rc[k][4];
    end
  end

  assign cout = c_blk[2];

endmodule

module csa_block_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int N  = WIDTH / 8;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_shift;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [7:0]       slice_y;
  logic             slice_c8;
  logic             accept;
  logic             last_slice;

  jcarryskipadder u_slice (
    .a    (a_sh[7:0]),
    .b    (b_sh[7:0]),
    .cin  (carry),
    .y    (slice_y),
    .cout (slice_c8)
  );

  // The new slice enters at the top so the first slice ends up in bits [7:0].
  generate
    if (WIDTH == 8) begin : g_one_slice
      assign sum_shift = slice_y;
    end else begin : g_multi_slice
      assign sum_shift = {slice_y, sum_sh[WIDTH-1:8]};
    end
  endgenerate

  assign accept     = (state == IDLE) && start_valid;
  assign last_slice = (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid)  state_nxt = RUN;
      RUN:     if (last_slice)   state_nxt = DONE;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      sum_sh <= '0;
      carry  <= cin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 8;
      b_sh   <= b_sh >> 8;
      sum_sh <= sum_shift;
      carry  <= slice_c8;
      cnt    <= cnt + 1'b1;
    end
  end

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign sum          = sum_sh;
  assign cout         = carry;

endmodule

// File: tb/tb_csa_block_serial_adder.sv
// Bench for the serial wide adder: scoreboard of expected sums from plain
// arithmetic, checked by a monitor whenever a result is presented.

module tb_csa_block_serial_adder;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        busy;

  logic        sv8 = 1'b0;
  logic        sr8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        cin8 = 1'b0;
  logic        rv8;
  logic        rr8 = 1'b1;
  logic [7:0]  sum8;
  logic        cout8;
  logic        busy8;

  csa_block_serial_adder #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .cin(cin), .result_valid(result_valid), .result_ready(result_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  csa_block_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .cin(cin8), .result_valid(rv8), .result_ready(rr8),
    .sum(sum8), .cout(cout8), .busy(busy8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        c;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   rr_rand = 1'b0;
  bit   prev_rv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rr_rand) result_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic ci);
    logic [32:0] full;
    int guard = 0;
    while (!start_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (!start_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: start_ready stayed %0b, expected 1", start_ready);
      return;
    end
    a = x;
    b = y;
    cin = ci;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    cin = 1'($urandom_range(0, 1));
    full = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    q.push_back('{s: full[31:0], c: full[32], acc: cyc});
  endtask

  task automatic drain();
    int guard = 0;
    while ((q.size() != 0 || !start_ready) && guard < 400) begin
      tick();
      guard++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Monitor: latency on the rising edge of result_valid, value on handshake,
  // stability and no-accept while the consumer stalls.
  always @(negedge clk) begin
    if (rst) begin
      prev_rv = 1'b0;
    end else begin
      if (result_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: sum %0h with nothing outstanding", sum);
        end else begin
          if (!prev_rv) check("latency", 64'(cyc - q[0].acc), 64'(N));
          if (result_ready) begin
            check("sum", 64'(sum), 64'(q[0].s));
            check("cout", 64'(cout), 64'(q[0].c));
            void'(q.pop_front());
          end else begin
            check("hold_sum", 64'({cout, sum}), 64'({q[0].c, q[0].s}));
            check("hold_start_ready", 64'(start_ready), 64'd0);
          end
        end
      end
      prev_rv = result_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    logic [31:0] y;

    // Reset asserted before any clock edge: outputs must already be cleared.
    #3;
    check("rst0_start_ready", 64'(start_ready), 64'd1);
    check("rst0_result_valid", 64'(result_valid), 64'd0);
    check("rst0_busy", 64'(busy), 64'd0);
    check("rst0_sum_cout", 64'({cout, sum}), 64'd0);
    #4 rst = 1'b0;

    // Basic op with timing checks.
    tick();
    issue(32'h1234_5678, 32'h8765_4321, 1'b1);
    check("t1_busy_after_accept", 64'(busy), 64'd1);
    repeat (3) tick();
    check("t1_not_valid_early", 64'(result_valid), 64'd0);
    tick();
    check("t1_valid", 64'(result_valid), 64'd1);
    check("t1_sum", 64'(sum), 64'h9999_999A);
    tick();
    check("t1_ready_again", 64'(start_ready), 64'd1);
    check("t1_valid_low", 64'(result_valid), 64'd0);
    check("t1_busy_low", 64'(busy), 64'd0);
    check("t1_sum_kept", 64'({cout, sum}), 64'h0_9999_999A);

    // Full-propagate slices.
    issue(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1);
    drain();
    check("t2_sum_cout", 64'({cout, sum}), 64'h1_0000_0000);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    drain();
    check("t3_sum_cout", 64'({cout, sum}), 64'h1_0000_0000);

    // Backpressure with new requests pending.
    result_ready = 1'b0;
    issue(32'hAAAA_5555, 32'h1234_ABCD, 1'b0);
    start_valid = 1'b1;
    repeat (N) tick();
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      b = $urandom;
      check("bp_valid", 64'(result_valid), 64'd1);
      check("bp_start_ready", 64'(start_ready), 64'd0);
      tick();
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    tick();
    issue(32'h0000_FFFF, 32'h0000_0001, 1'b1);
    drain();
    check("bp_second", 64'({cout, sum}), 64'h0_0001_0001);

    // Reset in the middle of RUN discards the operation.
    issue($urandom, $urandom, 1'b1);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    q.delete();
    check("rstrun_start_ready", 64'(start_ready), 64'd1);
    check("rstrun_result_valid", 64'(result_valid), 64'd0);
    check("rstrun_busy", 64'(busy), 64'd0);
    check("rstrun_sum_cout", 64'({cout, sum}), 64'd0);
    tick();
    #2 rst = 1'b0;
    issue(32'h0000_0001, 32'h0000_0001, 1'b0);
    drain();
    check("rstrun_after", 64'({cout, sum}), 64'h0_0000_0002);

    // Randomized traffic with random consumer stalls.
    rr_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin x = $urandom; y = ~x; end
        1: begin x = 32'hFFFF_FFFF; y = $urandom; end
        default: begin x = $urandom; y = $urandom; end
      endcase
      issue(x, y, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        if (!busy) begin
          n_cmp++;
          n_err++;
          $display("FAIL stray_accept: busy %0b, expected 1", busy);
        end
      end
    end
    rr_rand = 1'b0;
    result_ready = 1'b1;
    drain();

    // WIDTH=8: a single slice, one RUN cycle.
    a8 = 8'hFF;
    b8 = 8'h01;
    cin8 = 1'b1;
    check("w8_ready", 64'(sr8), 64'd1);
    sv8 = 1'b1;
    tick();
    sv8 = 1'b0;
    check("w8_busy", 64'(busy8), 64'd1);
    check("w8_not_valid_yet", 64'(rv8), 64'd0);
    tick();
    check("w8_valid", 64'(rv8), 64'd1);
    check("w8_sum_cout", 64'({cout8, sum8}), 64'h101);
    tick();
    check("w8_ready_again", 64'(sr8), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
